// File: rtl/dmem_responder.sv
// Handshaked data-memory target: word-organised RAM with byte-lane writes,
// a fixed access latency, and a registered response held until taken.
module dmem_responder #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [WIDTH/8-1:0]   req_be,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic                 resp_err
);

  localparam int BE_W  = WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [WIDTH-1:0]  wdata_p0;
  logic [BE_W-1:0]   be_p0;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              misaligned;
  logic              out_of_range;
  logic              access_err;
  logic              commit;
  logic [IDX_W-1:0]  idx;

  // Ready is decoded from state so that it is low for the whole reset pulse.
  assign req_ready    = (state == IDLE) && !rst;

  assign misaligned   = |addr_p0[1:0];
  assign out_of_range = 64'(addr_p0) >= SPAN;
  assign access_err   = misaligned || out_of_range;
  assign idx          = addr_p0[IDX_W+1:2];
  assign commit       = (state == BUSY) && (cnt == '0);

  // Stage p0: request capture at the accept edge; held until the next accept.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      be_p0    <= req_be;
    end
  end

  // Commit stage: RAM write on the BUSY->RESP edge, only for legal addresses.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_p0 && !access_err) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_p0[i]) begin
          mem[idx][8*i +: 8] <= wdata_p0[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= access_err;
            resp_rdata <= (!we_p0 && !access_err) ? mem[idx] : '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          // Return to IDLE rather than re-accepting in the handshake cycle.
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic checked against an associative-array memory model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1, req_ready1, req_we1;
  logic [15:0] req_addr1;
  logic [31:0] req_wdata1;
  logic [3:0]  req_be1;
  logic        resp_valid1, resp_ready1, resp_err1;
  logic [31:0] resp_rdata1;

  int checks;
  int errors;

  logic [31:0] mdl [int];

  dmem_responder #(.WIDTH(32), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.WIDTH(32), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // An access is illegal when misaligned or beyond the RAM's byte span.
  function automatic logic exp_err(input logic [15:0] a);
    return (a[1:0] != 2'b00) || (int'(a) >= DEPTH * 4);
  endfunction

  // Reference memory: returns the expected read data and applies writes.
  function automatic logic [31:0] model_apply(input logic we, input logic [15:0] a,
                                              input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    int key;
    key = int'(a[15:2]);
    if (exp_err(a)) return 32'h0;
    w = mdl.exists(key) ? mdl[key] : 32'h0;
    if (!we) return w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    end
    mdl[key] = w;
    return 32'h0;
  endfunction

  task automatic xact(input logic we, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rd, output logic er, output int lat,
                      output bit stable, output logic rdy_after, output logic rv_after);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = d;
    req_be     = be;
    resp_ready = (hold == 0);
    step();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    step();
    rdy_after = req_ready;
    rv_after  = resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
    checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL rst_release_ready1 got %b want 1", req_ready1); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, d;
    logic er, ra, rv;
    int lat;
    bit st;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      void'(model_apply(1'b1, 16'(w * 4), d, 4'hF));
      xact(1'b1, 16'(w * 4), d, 4'hF, 0, rd, er, lat, st, ra, rv);
    end
    xact(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, ra, rv);
    void'(model_apply(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF));
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", er); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", lat); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL wr_ready_after got %b want 1", ra); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL wr_valid_after got %b want 0", rv); end
    xact(1'b0, 16'h0010, 32'h0, 4'h0, 0, rd, er, lat, st, ra, rv);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", er); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic er, ra, rv;
    int lat;
    bit st;
    xact(1'b1, 16'h0020, 32'h11223344, 4'hF, 0, rd, er, lat, st, ra, rv);
    void'(model_apply(1'b1, 16'h0020, 32'h11223344, 4'hF));
    xact(1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat, st, ra, rv);
    void'(model_apply(1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101));
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lane_wr_err got %b want 0", er); end
    xact(1'b1, 16'h0020, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, st, ra, rv);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lane_be0_err got %b want 0", er); end
    xact(1'b0, 16'h0020, 32'h0, 4'h0, 0, rd, er, lat, st, ra, rv);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lane_rdata got %h want 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er, ra, rv;
    int lat;
    bit st;
    xact(1'b0, 16'h0012, 32'h0, 4'hF, 0, rd, er, lat, st, ra, rv);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_rd_err got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_rd_rdata got %h want 0", rd); end
    xact(1'b1, 16'h1000, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, st, ra, rv);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_wr_rdata got %h want 0", rd); end
    xact(1'b1, 16'h0002, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, st, ra, rv);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_wr_err got %b want 1", er); end
    xact(1'b0, 16'h0000, 32'h0, 4'h0, 0, rd, er, lat, st, ra, rv);
    checks++; if (rd !== mdl[0]) begin errors++; $display("FAIL word0_rdata got %h want %h", rd, mdl[0]); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word0_err got %b want 0", er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic er, ra, rv;
    int lat;
    bit st;
    xact(1'b0, 16'h0010, 32'h0, 4'h0, 5, rd, er, lat, st, ra, rv);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_rdata got %h want deadbeef", rd); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", st); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", ra); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b want 0", rv); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er, ra, rv;
    int lat;
    bit st;
    bit saw_valid;
    xact(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, st, ra, rv);
    void'(model_apply(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF));
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0030;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", req_ready); end
    saw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (resp_valid !== 1'b0) saw_valid = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (resp_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL midrst_resp_valid got 1 want 0"); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got %b want 1", req_ready); end
    xact(1'b0, 16'h0030, 32'h0, 4'h0, 0, rd, er, lat, st, ra, rv);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL midrst_rdata got %h want cafef00d", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp_rd;
    logic er, ra, rv, we;
    logic [15:0] a;
    logic [3:0] be;
    int lat, hold, kind;
    bit st;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      if (kind == 0)      a = 16'h1000 + 16'($urandom_range(0, 16'hEFFF));
      else if (kind == 1) a = 16'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else                a = 16'($urandom_range(0, 15) * 4);
      we   = 1'($urandom);
      d    = $urandom;
      be   = 4'($urandom);
      hold = $urandom_range(0, 2);
      exp_rd = model_apply(we, a, d, be);
      xact(we, a, d, be, hold, rd, er, lat, st, ra, rv);
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata n=%0d addr %h got %h want %h", n, a, rd, exp_rd); end
      checks++; if (er !== exp_err(a)) begin errors++; $display("FAIL rand_err n=%0d addr %h got %b want %b", n, a, er, exp_err(a)); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL rand_latency n=%0d got %0d want 2", n, lat); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL rand_stable n=%0d got %b want 1", n, st); end
    end
  endtask

  task automatic test_latency1();
    int acc_q[$];
    int rv_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] wd;
    bit acc;
    wd = $urandom;
    req_valid1  = 1'b1;
    req_we1     = 1'b1;
    req_addr1   = 16'h0040;
    req_wdata1  = wd;
    req_be1     = 4'hF;
    resp_ready1 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      acc = req_valid1 && req_ready1;
      step();
      if (acc) begin
        acc_q.push_back(c);
        req_we1 = 1'b0;
      end
      if (resp_valid1) begin
        rv_q.push_back(c);
        rd_q.push_back(resp_rdata1);
      end
    end
    req_valid1 = 1'b0;
    checks++; if (acc_q.size() !== 5) begin errors++; $display("FAIL lat1_accepts got %0d want 5", acc_q.size()); end
    checks++; if (rv_q.size() !== 5) begin errors++; $display("FAIL lat1_responses got %0d want 5", rv_q.size()); end
    for (int i = 0; i < acc_q.size() && i < rv_q.size(); i++) begin
      checks++; if (rv_q[i] !== acc_q[i] + 1) begin errors++; $display("FAIL lat1_resp_cycle i=%0d got %0d want %0d", i, rv_q[i], acc_q[i] + 1); end
      if (i > 0) begin
        checks++; if (acc_q[i] - acc_q[i-1] !== 3) begin errors++; $display("FAIL lat1_spacing i=%0d got %0d want 3", i, acc_q[i] - acc_q[i-1]); end
        checks++; if (rd_q[i] !== wd) begin errors++; $display("FAIL lat1_rdata i=%0d got %h want %h", i, rd_q[i], wd); end
      end else begin
        checks++; if (rd_q[i] !== 32'h0) begin errors++; $display("FAIL lat1_wr_rdata got %h want 0", rd_q[i]); end
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_be      = '0;
    resp_ready  = 1'b1;
    req_valid1  = 1'b0;
    req_we1     = 1'b0;
    req_addr1   = '0;
    req_wdata1  = '0;
    req_be1     = '0;
    resp_ready1 = 1'b1;

    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_latency1();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Handshaked data-memory responder. It serves the CPU load/store port as the target (slave) end of a valid/ready request/response protocol. It holds a word-organised RAM with byte-lane writes and a fixed, parameterised access latency. It replaces the zero-latency combinational dmem so that the CPU's memory stage can be exercised with wait states.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 16, byte-address width (matches the 16-bit PC/SP space).
DEPTH, 1024, number of WIDTH-bit words; power of 2.
LATENCY, 2, clock edges from request accept to response valid; must be ≥1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  byte address
req_wdata  input  WIDTH  write data
req_be  input  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  requester can take the response
resp_rdata  output  WIDTH  read data; 0 for writes and errors
resp_err  output  1  misaligned or out-of-range access

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- State on reset: FSM goes to IDLE, latency counter to 0, resp_valid 0, resp_rdata 0, resp_err 0.
- req_ready during reset: forced 0 while rst is high.
- RAM on reset: contents are NOT reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid && req_ready (the accept edge E):
    - latch req_we, req_addr, req_wdata, req_be;
    - load cnt = LATENCY-1;
    - go to BUSY.
- BUSY:
  - req_ready = 0.
  - On each edge: if cnt == 0, perform the access and go to RESP; otherwise cnt decrements.
  - resp_valid therefore rises exactly LATENCY edges after E (after edge E+LATENCY).
- Access, performed on the BUSY→RESP edge:
  - Word index = addr[log2(DEPTH)+1 : 2].
  - Misaligned: addr[1:0] != 0 → resp_err = 1, no RAM write, resp_rdata = 0.
  - Out of range: addr ≥ DEPTH*4 → resp_err = 1, no RAM write, resp_rdata = 0. Misaligned takes no extra priority; either condition alone sets err.
  - Valid write: only the byte lanes with be = 1 are updated; resp_rdata = 0, resp_err = 0. be = 0 is a legal no-op (err = 0).
  - Valid read: be is ignored and the full word is returned in resp_rdata, registered.
- RESP:
  - req_ready = 0, resp_valid = 1.
  - resp_rdata and resp_err stay stable until the edge where resp_valid && resp_ready, then go to IDLE.
  - On that transition resp_valid drops; resp_rdata and resp_err may hold their stale values.
  - No same-cycle re-accept: the next request is accepted at the earliest one cycle after the handshake. Minimum period is LATENCY+2 cycles per transaction.
- Protocol rules:
  - The requester may change req_* freely while req_ready = 0; they are only sampled at the accept edge.
  - resp_ready may be held high continuously.
- Reset mid-operation: asserting rst in BUSY before the commit edge discards the pending write (RAM is not modified). Asserting rst in RESP drops the response. The FSM is in IDLE, with req_ready = 1, on the first edge after rst deasserts.
- Read-after-write: a read accepted after a write's response handshake returns the new data.

Test Plan:
- Write then read (LATENCY = 2): write addr 0x0010, wdata 0xDEADBEEF, be 0xF; then read 0x0010 → write response at E+2 with rdata 0 and err 0; read resp_rdata 0xDEADBEEF, err 0.
- Byte lanes: preload 0x11223344 at 0x0020; write wdata 0xAABBCCDD with be 0b0101 → a subsequent read returns 0x11BB33DD.
- Errors:
  - read 0x0012 → err 1, rdata 0;
  - write 0x1000 (DEPTH = 1024, so ≥ 0x1000 is out of range) → err 1;
  - a re-read of word 0 is unchanged.
- Backpressure: hold resp_ready = 0 for 5 cycles after resp_valid → resp_valid, rdata and err are stable and req_ready stays 0; raise resp_ready → handshake; req_ready = 1 the next cycle.
- Reset mid-operation: write 0x0030 = 0x12345678, assert rst one cycle after accept (in BUSY) → resp_valid never rises; after release, a read of 0x0030 returns the prior contents.
- LATENCY = 1 build: back-to-back reads with resp_ready tied to 1 → resp_valid one edge after each accept; accepts are spaced exactly 3 cycles apart.
